obi_sram_bank_arbiter: RTL and testbench

//  Shares one single-port SRAM bank between NumMgr OBI requesters using round-robin

---
 rtl/obi_sram_bank_arbiter.sv | 151 +++++++++++++++
 tb/tb_obi_sram_bank_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_bank_arbiter.sv
// obi_sram_bank_arbiter
// Round-robin sharing of one single-port SRAM bank between NumMgr OBI managers.
// One request is granted per cycle; its response comes back on the next cycle
// to the granted manager only, over shared rdata/rid/err buses.
module obi_sram_bank_arbiter #(
    parameter int NumMgr         = 4,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int IdWidth        = 1,
    parameter int BankNumWords   = 512,
    localparam int BankAddrWidth = (BankNumWords > 1) ? $clog2(BankNumWords) : 1,
    localparam int BeWidth       = DataWidth / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumMgr-1:0]             mgr_req_i,
    input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]             mgr_we_i,
    input  logic [NumMgr*BeWidth-1:0]     mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
    input  logic [NumMgr*IdWidth-1:0]     mgr_aid_i,
    output logic [NumMgr-1:0]             mgr_gnt_o,
    output logic [NumMgr-1:0]             mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic [IdWidth-1:0]            mgr_rid_o,
    output logic                          mgr_err_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [BankAddrWidth-1:0]      sram_addr_o,
    output logic [BeWidth-1:0]            sram_be_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    input  logic [DataWidth-1:0]          sram_rdata_i
);

    localparam int MgrIdxWidth = (NumMgr > 1) ? $clog2(NumMgr) : 1;

    logic [BankAddrWidth-1:0] word_arr  [NumMgr];
    logic [1:0]               mis_arr   [NumMgr];
    logic [BeWidth-1:0]       be_arr    [NumMgr];
    logic [DataWidth-1:0]     wdata_arr [NumMgr];
    logic [IdWidth-1:0]       aid_arr   [NumMgr];

    logic [MgrIdxWidth-1:0]   rr_ptr;
    logic [MgrIdxWidth-1:0]   winner;
    logic [MgrIdxWidth:0]     cand;
    logic                     found;
    logic                     grant;
    logic                     req_err;

    logic                     rsp_valid;
    logic [MgrIdxWidth-1:0]   rsp_mgr;
    logic [IdWidth-1:0]       rsp_id;
    logic                     rsp_err;
    logic                     rsp_we;

    // Address bits above the bank word index are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^mgr_addr_i;

    // Split the flat per-manager buses into indexable per-manager fields
    always_comb begin
        for (int m = 0; m < NumMgr; m++) begin
            word_arr[m]  = mgr_addr_i[m*AddrWidth+2 +: BankAddrWidth];
            mis_arr[m]   = mgr_addr_i[m*AddrWidth +: 2];
            be_arr[m]    = mgr_be_i[m*BeWidth +: BeWidth];
            wdata_arr[m] = mgr_wdata_i[m*DataWidth +: DataWidth];
            aid_arr[m]   = mgr_aid_i[m*IdWidth +: IdWidth];
        end
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping around
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NumMgr; i++) begin
            cand = {1'b0, rr_ptr} + (MgrIdxWidth+1)'(i);
            if (cand >= (MgrIdxWidth+1)'(NumMgr)) begin
                cand = cand - (MgrIdxWidth+1)'(NumMgr);
            end
            if (!found && mgr_req_i[cand[MgrIdxWidth-1:0]]) begin
                found  = 1'b1;
                winner = cand[MgrIdxWidth-1:0];
            end
        end
    end

    assign grant = found & rst_ni;

    // Grant the winner and steer its request onto the SRAM port; misaligned writes lose their byte enables
    always_comb begin
        mgr_gnt_o    = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        req_err      = 1'b0;
        if (grant) begin
            mgr_gnt_o[winner] = 1'b1;
            req_err           = (mis_arr[winner] != 2'b00);
            sram_req_o        = 1'b1;
            sram_we_o         = mgr_we_i[winner];
            sram_addr_o       = word_arr[winner];
            sram_be_o         = (mgr_we_i[winner] && req_err) ? '0 : be_arr[winner];
            sram_wdata_o      = wdata_arr[winner];
        end
    end

    // Advance the pointer past each winner and capture the response context one cycle ahead
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_mgr   <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= grant;
            if (grant) begin
                rr_ptr  <= (winner == MgrIdxWidth'(NumMgr - 1)) ? '0 : winner + MgrIdxWidth'(1);
                rsp_mgr <= winner;
                rsp_id  <= aid_arr[winner];
                rsp_err <= req_err;
                rsp_we  <= mgr_we_i[winner];
            end
        end
    end

    // Route the response to its manager; data only for clean reads, and nothing while in reset
    always_comb begin
        mgr_rvalid_o = '0;
        mgr_rdata_o  = '0;
        mgr_rid_o    = '0;
        mgr_err_o    = 1'b0;
        if (rst_ni) begin
            mgr_rvalid_o[rsp_mgr] = rsp_valid;
            mgr_rid_o             = rsp_id;
            mgr_err_o             = rsp_err & rsp_valid;
            if (rsp_valid && !rsp_we && !rsp_err) begin
                mgr_rdata_o = sram_rdata_i;
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(mgr_gnt_o));
    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(mgr_rvalid_o));
    a_gnt_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni) (mgr_gnt_o & ~mgr_req_i) == '0);

endmodule

// File: tb/tb_obi_sram_bank_arbiter.sv
// tb_obi_sram_bank_arbiter
// Directed scenarios plus randomized traffic checked against a behavioural
// round-robin / memory model kept inside the bench.
module tb_obi_sram_bank_arbiter;

    localparam int NumMgr        = 4;
    localparam int AddrWidth     = 32;
    localparam int DataWidth     = 32;
    localparam int IdWidth       = 1;
    localparam int BankNumWords  = 512;
    localparam int BankAddrWidth = 9;
    localparam int BeWidth       = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    logic [NumMgr-1:0]           mgr_req_i;
    logic [NumMgr*AddrWidth-1:0] mgr_addr_i;
    logic [NumMgr-1:0]           mgr_we_i;
    logic [NumMgr*BeWidth-1:0]   mgr_be_i;
    logic [NumMgr*DataWidth-1:0] mgr_wdata_i;
    logic [NumMgr*IdWidth-1:0]   mgr_aid_i;
    logic [NumMgr-1:0]           mgr_gnt_o;
    logic [NumMgr-1:0]           mgr_rvalid_o;
    logic [DataWidth-1:0]        mgr_rdata_o;
    logic [IdWidth-1:0]          mgr_rid_o;
    logic                        mgr_err_o;
    logic                        sram_req_o;
    logic                        sram_we_o;
    logic [BankAddrWidth-1:0]    sram_addr_o;
    logic [BeWidth-1:0]          sram_be_o;
    logic [DataWidth-1:0]        sram_wdata_o;
    logic [DataWidth-1:0]        sram_rdata_i = '0;

    logic [AddrWidth-1:0] drv_addr  [NumMgr];
    logic [BeWidth-1:0]   drv_be    [NumMgr];
    logic [DataWidth-1:0] drv_wdata [NumMgr];
    logic [IdWidth-1:0]   drv_aid   [NumMgr];

    logic [DataWidth-1:0] sram_mem [BankNumWords];
    logic [DataWidth-1:0] ref_mem  [BankNumWords];
    logic                 load_mem = 1'b0;

    int                   m_ptr;
    bit                   m_valid;
    int                   m_mgr;
    logic [IdWidth-1:0]   m_id;
    bit                   m_err;
    logic [DataWidth-1:0] m_rdata;

    logic [NumMgr-1:0]        e_gnt;
    logic                     e_req;
    logic [BankAddrWidth-1:0] e_addr;
    logic                     e_we;
    logic [BeWidth-1:0]       e_be;
    logic [DataWidth-1:0]     e_wdata;
    logic [NumMgr-1:0]        e_rvalid;
    logic                     e_err;
    logic [DataWidth-1:0]     e_rdata;
    logic [IdWidth-1:0]       e_rid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    obi_sram_bank_arbiter #(
        .NumMgr(NumMgr), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
        .IdWidth(IdWidth), .BankNumWords(BankNumWords)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
        .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
        .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
        .mgr_rid_o(mgr_rid_o), .mgr_err_o(mgr_err_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    // Pack the per-manager drive fields onto the flat DUT buses
    always_comb begin
        for (int m = 0; m < NumMgr; m++) begin
            mgr_addr_i[m*AddrWidth +: AddrWidth]  = drv_addr[m];
            mgr_be_i[m*BeWidth +: BeWidth]        = drv_be[m];
            mgr_wdata_i[m*DataWidth +: DataWidth] = drv_wdata[m];
            mgr_aid_i[m*IdWidth +: IdWidth]       = drv_aid[m];
        end
    end

    // Single-port SRAM macro: one-cycle read latency, byte-masked writes, bulk preload while in reset
    always @(posedge clk_i) begin
        if (load_mem) begin
            for (int i = 0; i < BankNumWords; i++) sram_mem[i] <= ref_mem[i];
        end else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BeWidth; b++) begin
                    if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
                end
            end
            sram_rdata_i <= sram_mem[sram_addr_o];
        end
    end

    // Reference round-robin choice: first requester at or after ptr, modulo NumMgr
    function automatic int model_winner(input logic [NumMgr-1:0] req, input int ptr);
        for (int k = 0; k < NumMgr; k++) begin
            if (req[(ptr + k) % NumMgr]) return (ptr + k) % NumMgr;
        end
        return -1;
    endfunction

    // Expected DUT outputs in the current cycle from current inputs and model state
    task automatic model_expect();
        int w;
        e_gnt = '0; e_req = 1'b0; e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
        e_rvalid = '0; e_err = 1'b0; e_rdata = '0; e_rid = m_id;
        if (!rst_ni) return;
        w = model_winner(mgr_req_i, m_ptr);
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_req    = 1'b1;
            e_addr   = BankAddrWidth'(drv_addr[w] >> 2);
            e_we     = mgr_we_i[w];
            e_be     = (mgr_we_i[w] && drv_addr[w][1:0] != 2'b00) ? '0 : drv_be[w];
            e_wdata  = drv_wdata[w];
        end
        if (m_valid) begin
            e_rvalid[m_mgr] = 1'b1;
            e_err           = m_err;
            e_rdata         = m_rdata;
        end
    endtask

    // Advance the model by one clock: pointer, memory contents and pending response
    task automatic model_tick();
        int w;
        int word;
        if (!rst_ni) begin
            m_ptr = 0; m_valid = 0; m_mgr = 0; m_id = '0; m_err = 0; m_rdata = '0;
            return;
        end
        w = model_winner(mgr_req_i, m_ptr);
        m_valid = (w >= 0);
        if (w >= 0) begin
            m_ptr = (w + 1) % NumMgr;
            word  = int'((drv_addr[w] >> 2) % BankNumWords);
            m_mgr = w;
            m_id  = drv_aid[w];
            m_err = (drv_addr[w][1:0] != 2'b00);
            if (mgr_we_i[w]) begin
                m_rdata = '0;
                if (!m_err) begin
                    for (int b = 0; b < BeWidth; b++) begin
                        if (drv_be[w][b]) ref_mem[word][b*8 +: 8] = drv_wdata[w][b*8 +: 8];
                    end
                end
            end else begin
                m_rdata = m_err ? '0 : ref_mem[word];
            end
        end
    endtask

    task automatic next_cycle();
        model_tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        mgr_req_i = '0;
        mgr_we_i  = '0;
        for (int m = 0; m < NumMgr; m++) begin
            drv_addr[m] = '0; drv_be[m] = '0; drv_wdata[m] = '0; drv_aid[m] = '0;
        end
    endtask

    task automatic randomize_inputs();
        mgr_req_i = NumMgr'($urandom);
        mgr_we_i  = NumMgr'($urandom);
        for (int m = 0; m < NumMgr; m++) begin
            drv_addr[m]  = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2)
                         | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            drv_be[m]    = BeWidth'($urandom);
            drv_wdata[m] = $urandom;
            drv_aid[m]   = IdWidth'($urandom);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_ni   = 1'b0;
        load_mem = 1'b1;
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            #2;
            n_checks++; if (mgr_gnt_o !== '0) $display("[TB] FAIL reset_gnt: got %b want 0", mgr_gnt_o); else n_pass++;
            n_checks++; if (sram_req_o !== 1'b0) $display("[TB] FAIL reset_sram_req: got %b want 0", sram_req_o); else n_pass++;
            n_checks++; if (mgr_rvalid_o !== '0) $display("[TB] FAIL reset_rvalid: got %b want 0", mgr_rvalid_o); else n_pass++;
            next_cycle();
        end
        load_mem = 1'b0;
        rst_ni   = 1'b1;
        clear_inputs();
        #2;
        n_checks++; if (mgr_rvalid_o !== '0) $display("[TB] FAIL post_reset_rvalid: got %b want 0", mgr_rvalid_o); else n_pass++;
        n_checks++; if (mgr_err_o !== 1'b0) $display("[TB] FAIL post_reset_err: got %b want 0", mgr_err_o); else n_pass++;
        n_checks++; if (mgr_rdata_o !== '0) $display("[TB] FAIL post_reset_rdata: got %h want 0", mgr_rdata_o); else n_pass++;
        next_cycle();
    endtask

    task automatic test_single_read();
        logic [DataWidth-1:0] want;
        $display("[TB] test_single_read");
        clear_inputs();
        mgr_req_i   = 4'b0010;
        drv_addr[1] = 32'h0000_0010;
        drv_aid[1]  = 1'b1;
        drv_be[1]   = 4'hF;
        want        = ref_mem[4];
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0010) $display("[TB] FAIL single_gnt: got %b want 0010", mgr_gnt_o); else n_pass++;
        n_checks++; if (sram_addr_o !== 9'd4) $display("[TB] FAIL single_sram_addr: got %0d want 4", sram_addr_o); else n_pass++;
        n_checks++; if (sram_we_o !== 1'b0) $display("[TB] FAIL single_sram_we: got %b want 0", sram_we_o); else n_pass++;
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (mgr_rvalid_o !== 4'b0010) $display("[TB] FAIL single_rvalid: got %b want 0010", mgr_rvalid_o); else n_pass++;
        n_checks++; if (mgr_rid_o !== 1'b1) $display("[TB] FAIL single_rid: got %b want 1", mgr_rid_o); else n_pass++;
        n_checks++; if (mgr_rdata_o !== want) $display("[TB] FAIL single_rdata: got %h want %h", mgr_rdata_o, want); else n_pass++;
        n_checks++; if (mgr_err_o !== 1'b0) $display("[TB] FAIL single_err: got %b want 0", mgr_err_o); else n_pass++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        int start;
        int cnt [NumMgr];
        logic [NumMgr-1:0] want;
        $display("[TB] test_round_robin");
        start = m_ptr;
        for (int m = 0; m < NumMgr; m++) cnt[m] = 0;
        clear_inputs();
        mgr_req_i = '1;
        for (int m = 0; m < NumMgr; m++) begin
            drv_addr[m] = 32'(m * 4);
            drv_be[m]   = 4'hF;
            drv_aid[m]  = IdWidth'(m);
        end
        for (int c = 0; c < 12; c++) begin
            #2;
            want = NumMgr'(1) << ((start + c) % NumMgr);
            n_checks++; if (mgr_gnt_o !== want) $display("[TB] FAIL rr_gnt cyc %0d: got %b want %b", c, mgr_gnt_o, want); else n_pass++;
            if (c > 0) begin
                want = NumMgr'(1) << ((start + c - 1) % NumMgr);
                n_checks++; if (mgr_rvalid_o !== want) $display("[TB] FAIL rr_rvalid cyc %0d: got %b want %b", c, mgr_rvalid_o, want); else n_pass++;
            end
            for (int m = 0; m < NumMgr; m++) if (mgr_gnt_o[m] === 1'b1) cnt[m]++;
            next_cycle();
        end
        for (int m = 0; m < NumMgr; m++) begin
            n_checks++; if (cnt[m] != 3) $display("[TB] FAIL rr_share mgr%0d: got %0d grants want 3", m, cnt[m]); else n_pass++;
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_write_read();
        logic [DataWidth-1:0] old;
        logic [DataWidth-1:0] want;
        $display("[TB] test_write_read");
        old  = ref_mem[2];
        want = {old[31:16], 16'hBEEF};
        clear_inputs();
        mgr_req_i    = 4'b0100;
        mgr_we_i     = 4'b0100;
        drv_addr[2]  = 32'h8;
        drv_be[2]    = 4'b0011;
        drv_wdata[2] = 32'hDEAD_BEEF;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0100) $display("[TB] FAIL wr_gnt: got %b want 0100", mgr_gnt_o); else n_pass++;
        n_checks++; if (sram_be_o !== 4'b0011) $display("[TB] FAIL wr_sram_be: got %b want 0011", sram_be_o); else n_pass++;
        n_checks++; if (sram_wdata_o !== 32'hDEAD_BEEF) $display("[TB] FAIL wr_sram_wdata: got %h want deadbeef", sram_wdata_o); else n_pass++;
        next_cycle();
        mgr_we_i = '0;
        drv_be[2] = 4'hF;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0100) $display("[TB] FAIL rd_gnt_b2b: got %b want 0100", mgr_gnt_o); else n_pass++;
        n_checks++; if (mgr_rvalid_o !== 4'b0100) $display("[TB] FAIL wr_rvalid: got %b want 0100", mgr_rvalid_o); else n_pass++;
        n_checks++; if (mgr_rdata_o !== '0) $display("[TB] FAIL wr_rdata: got %h want 0", mgr_rdata_o); else n_pass++;
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (mgr_rvalid_o !== 4'b0100) $display("[TB] FAIL rd_rvalid: got %b want 0100", mgr_rvalid_o); else n_pass++;
        n_checks++; if (mgr_rdata_o !== want) $display("[TB] FAIL rd_merged: got %h want %h", mgr_rdata_o, want); else n_pass++;
        next_cycle();
    endtask

    task automatic test_misaligned();
        logic [DataWidth-1:0] old;
        $display("[TB] test_misaligned");
        old = ref_mem[1];
        clear_inputs();
        mgr_req_i    = 4'b0001;
        mgr_we_i     = 4'b0001;
        drv_addr[0]  = 32'h6;
        drv_be[0]    = 4'hF;
        drv_wdata[0] = ~old;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0001) $display("[TB] FAIL mis_gnt: got %b want 0001", mgr_gnt_o); else n_pass++;
        n_checks++; if (sram_be_o !== 4'b0000) $display("[TB] FAIL mis_sram_be: got %b want 0000", sram_be_o); else n_pass++;
        n_checks++; if (sram_addr_o !== 9'd1) $display("[TB] FAIL mis_sram_addr: got %0d want 1", sram_addr_o); else n_pass++;
        next_cycle();
        mgr_we_i    = '0;
        drv_addr[0] = 32'h4;
        #2;
        n_checks++; if (mgr_rvalid_o !== 4'b0001) $display("[TB] FAIL mis_rvalid: got %b want 0001", mgr_rvalid_o); else n_pass++;
        n_checks++; if (mgr_err_o !== 1'b1) $display("[TB] FAIL mis_err: got %b want 1", mgr_err_o); else n_pass++;
        n_checks++; if (mgr_rdata_o !== '0) $display("[TB] FAIL mis_rdata: got %h want 0", mgr_rdata_o); else n_pass++;
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (mgr_rdata_o !== old) $display("[TB] FAIL mis_mem_kept: got %h want %h", mgr_rdata_o, old); else n_pass++;
        n_checks++; if (mgr_err_o !== 1'b0) $display("[TB] FAIL mis_err_clear: got %b want 0", mgr_err_o); else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        clear_inputs();
        mgr_req_i = 4'b0100;
        drv_be[2] = 4'hF;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0100) $display("[TB] FAIL rstmid_gnt: got %b want 0100", mgr_gnt_o); else n_pass++;
        next_cycle();
        rst_ni = 1'b0;
        clear_inputs();
        #2;
        n_checks++; if (mgr_rvalid_o !== '0) $display("[TB] FAIL rstmid_dropped: got %b want 0", mgr_rvalid_o); else n_pass++;
        next_cycle();
        rst_ni = 1'b1;
        #2;
        n_checks++; if (mgr_rvalid_o !== '0) $display("[TB] FAIL rstmid_after: got %b want 0", mgr_rvalid_o); else n_pass++;
        next_cycle();
        mgr_req_i = 4'b1010;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0010) $display("[TB] FAIL rstmid_ptr0: got %b want 0010", mgr_gnt_o); else n_pass++;
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (mgr_rvalid_o !== 4'b0010) $display("[TB] FAIL rstmid_rvalid: got %b want 0010", mgr_rvalid_o); else n_pass++;
        next_cycle();
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        clear_inputs();
        mgr_req_i = 4'b0100;
        next_cycle();
        mgr_req_i = 4'b1001;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b1000) $display("[TB] FAIL wrap_first: got %b want 1000", mgr_gnt_o); else n_pass++;
        next_cycle();
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0001) $display("[TB] FAIL wrap_second: got %b want 0001", mgr_gnt_o); else n_pass++;
        next_cycle();
        mgr_req_i = 4'b0011;
        #2;
        n_checks++; if (mgr_gnt_o !== 4'b0010) $display("[TB] FAIL wrap_ptr1: got %b want 0010", mgr_gnt_o); else n_pass++;
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            #2;
            model_expect();
            n_checks++; if (mgr_gnt_o !== e_gnt) $display("[TB] FAIL rand_gnt cyc %0d: got %b want %b", c, mgr_gnt_o, e_gnt); else n_pass++;
            n_checks++; if (sram_req_o !== e_req) $display("[TB] FAIL rand_sram_req cyc %0d: got %b want %b", c, sram_req_o, e_req); else n_pass++;
            if (e_req) begin
                n_checks++;
                if (sram_addr_o !== e_addr || sram_we_o !== e_we || sram_be_o !== e_be || sram_wdata_o !== e_wdata)
                    $display("[TB] FAIL rand_sram_drive cyc %0d: got a=%0d we=%b be=%b d=%h want a=%0d we=%b be=%b d=%h",
                             c, sram_addr_o, sram_we_o, sram_be_o, sram_wdata_o, e_addr, e_we, e_be, e_wdata);
                else n_pass++;
            end
            n_checks++; if (mgr_rvalid_o !== e_rvalid) $display("[TB] FAIL rand_rvalid cyc %0d: got %b want %b", c, mgr_rvalid_o, e_rvalid); else n_pass++;
            n_checks++; if (mgr_err_o !== e_err) $display("[TB] FAIL rand_err cyc %0d: got %b want %b", c, mgr_err_o, e_err); else n_pass++;
            if (e_rvalid != '0) begin
                n_checks++; if (mgr_rdata_o !== e_rdata) $display("[TB] FAIL rand_rdata cyc %0d: got %h want %h", c, mgr_rdata_o, e_rdata); else n_pass++;
                n_checks++; if (mgr_rid_o !== e_rid) $display("[TB] FAIL rand_rid cyc %0d: got %b want %b", c, mgr_rid_o, e_rid); else n_pass++;
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        m_ptr = 0; m_valid = 0; m_mgr = 0; m_id = '0; m_err = 0; m_rdata = '0;
        for (int i = 0; i < BankNumWords; i++) ref_mem[i] = $urandom;
        @(posedge clk_i);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
